sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Shares the single 32×32 SRAM port between the host command path (UART-driven read/write controller) and the DPU. Each requester presents a valid/ready-style access request; the block arbitrates, registers the SRAM strobes, and returns read data to the winner with a per-port valid pulse. A DPU lock keeps ownership across read-modify-write sequences so host traffic cannot interleave.

## Interface
- ADDR_W, 5, SRAM word address width
- DATA_W, 32, SRAM word width
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- h_req  in  1  host access request (level, held until granted)
- h_we  in  1  host: 1 = write, 0 = read
- h_addr  in  ADDR_W  host address
- h_wdata  in  DATA_W  host write data
- h_gnt  out  1  host request accepted this cycle
- h_rvalid  out  1  one-cycle pulse, h_rdata valid
- h_rdata  out  DATA_W  host read data (held until next host read)
- d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata  same as host set, DPU side
- d_lock  in  1  DPU requests exclusive ownership
- sram_csb_n  out  1  SRAM chip select, active low
- sram_we_n  out  1  SRAM write enable, active low (1 = read)
- sram_addr  out  ADDR_W  SRAM address
- sram_din  out  DATA_W  SRAM write data
- sram_dout  in  DATA_W  SRAM read data, valid the cycle after the access cycle
- busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, ACCESS, RDWAIT.
- IDLE: select winner among h_req/d_req; drive x_gnt=1 combinationally for winner only. Transfer = x_req && x_gnt. On transfer: latch we/addr/wdata into SRAM output registers, record owner and kind, → ACCESS. No request → stay IDLE, gnt=0.
- ACCESS: sram_csb_n=0, sram_we_n=!we, addr/din from latched fields. Write → IDLE. Read → RDWAIT.
- RDWAIT: sram_csb_n=1; capture sram_dout into owner's x_rdata; x_rvalid=1 on next cycle; → IDLE.
- gnt only ever asserted in IDLE; never both gnts in one cycle.
- Tie-break: see Configuration.
- Lock: lock_q set when a DPU transfer occurs with d_lock=1. While lock_q=1, h_gnt=0 regardless of h_req. lock_q clears in IDLE when d_lock=0 (evaluated before arbitration that cycle, so host may be granted the same cycle).
- Requester may change fields or present a new request the cycle after its gnt.
- Outside ACCESS: sram_csb_n=1, sram_we_n=1; sram_addr/din hold last value.

## Timing
- Reset values: sram_csb_n=1, sram_we_n=1, sram_addr=0, sram_din=0, h_/d_gnt=0, h_/d_rvalid=0, h_/d_rdata=0, busy=0, lock_q=0, last-served pointer = DPU, state IDLE.
- Read: transfer in cycle N, ACCESS cycle N+1, RDWAIT N+2, x_rvalid and x_rdata at N+3 (state IDLE, new grant allowed in N+3). Throughput 1 read / 3 cycles.
- Write: transfer N, ACCESS N+1, IDLE N+2. Throughput 1 write / 2 cycles.
- rst mid-operation: next cycle all outputs at reset values, pending read dropped, no rvalid, lock cleared.
- Request dropped before gnt: legal, no access.
- x_rdata holds value until that port's next read completes.

## Configuration
- SRAM_ARB_RR_EN defined: round-robin — on simultaneous h_req and d_req (unlocked), grant the port not served last; pointer updates on every transfer.
- Undefined: fixed priority, DPU always wins ties; pointer logic absent. Lock behaviour identical in both builds.

## Test plan
- Host write addr 5 data 0xDEADBEEF, then host read addr 5 -> ACCESS with csb_n=0/we_n=0/addr=5/din=0xDEADBEEF; h_rvalid 3 cycles after read gnt with h_rdata=0xDEADBEEF.
- h_req and d_req both held continuously, reads -> RR build: gnts alternate host, DPU, host (host first after reset); fixed build: DPU granted every time, host starves.
- DPU read addr 3 with d_lock=1, host req held, DPU write addr 3 then d_lock=0 -> h_gnt stays 0 until first IDLE with d_lock=0; host granted that cycle.
- Back-to-back DPU writes addr 0..3 -> csb_n low every other cycle, 4 writes in 8 cycles, no rvalid.
- rst asserted in RDWAIT of host read -> no h_rvalid, h_rdata=0, csb_n=1, busy=0 next cycle.
- Host read data returned to DPU port check: DPU read while host rdata held -> only d_rvalid pulses, h_rdata unchanged.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Arbitrates one single-port SRAM between the host command path and the DPU, with a DPU lock for read-modify-write.
// Optional build macro SRAM_ARB_RR_EN: round-robin tie-break; undefined gives fixed DPU priority.
module sram_port_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              d_lock,
    output logic              sram_csb_n,
    output logic              sram_we_n,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_t;

    state_t state;
    logic   owner_dpu;
    logic   we_q;
    logic   lock_q;
    logic   h_ok;
    logic   h_xfer;
    logic   d_xfer;

    // A held lock only blocks the host while d_lock is still asserted, so release and host grant share a cycle.
    assign h_ok   = h_req && !(lock_q && d_lock);
    assign h_xfer = h_req && h_gnt;
    assign d_xfer = d_req && d_gnt;
    assign busy   = (state != IDLE);

`ifdef SRAM_ARB_RR_EN
    logic last_host;

    always_comb begin
        h_gnt = 1'b0;
        d_gnt = 1'b0;
        if (state == IDLE && !rst) begin
            if (h_ok && d_req) begin
                h_gnt = !last_host;
                d_gnt = last_host;
            end else begin
                h_gnt = h_ok;
                d_gnt = d_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_host <= 1'b0;
        end else if (h_xfer || d_xfer) begin
            last_host <= h_xfer;
        end
    end
`else
    always_comb begin
        h_gnt = 1'b0;
        d_gnt = 1'b0;
        if (state == IDLE && !rst) begin
            d_gnt = d_req;
            h_gnt = h_ok && !d_req;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner_dpu  <= 1'b0;
            we_q       <= 1'b0;
            lock_q     <= 1'b0;
            sram_csb_n <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_addr  <= '0;
            sram_din   <= '0;
            h_rvalid   <= 1'b0;
            d_rvalid   <= 1'b0;
            h_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            h_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_xfer && d_lock) begin
                        lock_q <= 1'b1;
                    end else if (!d_lock) begin
                        lock_q <= 1'b0;
                    end
                    if (h_xfer || d_xfer) begin
                        owner_dpu  <= d_xfer;
                        we_q       <= d_xfer ? d_we : h_we;
                        sram_csb_n <= 1'b0;
                        sram_we_n  <= d_xfer ? !d_we : !h_we;
                        sram_addr  <= d_xfer ? d_addr : h_addr;
                        sram_din   <= d_xfer ? d_wdata : h_wdata;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    sram_csb_n <= 1'b1;
                    sram_we_n  <= 1'b1;
                    state      <= we_q ? IDLE : RDWAIT;
                end
                RDWAIT: begin
                    // SRAM data lands the cycle after the access strobe.
                    if (owner_dpu) begin
                        d_rdata  <= sram_dout;
                        d_rvalid <= 1'b1;
                    end else begin
                        h_rdata  <= sram_dout;
                        h_rvalid <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter with a behavioural synchronous-read SRAM.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        h_req, h_we, h_gnt, h_rvalid;
    logic [4:0]  h_addr;
    logic [31:0] h_wdata, h_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, d_lock;
    logic [4:0]  d_addr;
    logic [31:0] d_wdata, d_rdata;
    logic        sram_csb_n, sram_we_n, busy;
    logic [4:0]  sram_addr;
    logic [31:0] sram_din, sram_dout;

    logic [31:0] mem [32];
    int          errors = 0;
    int          checks = 0;
    logic        exp_h [3];
    logic        exp_d [3];

    always #5 clk = ~clk;

    sram_port_arbiter dut (
        .clk(clk), .rst(rst),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_lock(d_lock),
        .sram_csb_n(sram_csb_n), .sram_we_n(sram_we_n), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout), .busy(busy)
    );

    // Behavioural SRAM: write on strobe, read data registered for the following cycle.
    always @(posedge clk) begin
        if (!sram_csb_n) begin
            if (!sram_we_n) mem[sram_addr] <= sram_din;
            else            sram_dout      <= mem[sram_addr];
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic hr, input logic hw, input logic [4:0] ha,
                                 input logic [31:0] hd, input logic dr, input logic dw,
                                 input logic [4:0] da, input logic [31:0] dd, input logic dl);
        h_req = hr; h_we = hw; h_addr = ha; h_wdata = hd;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd; d_lock = dl;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        sram_dout = 32'h0;
`ifdef SRAM_ARB_RR_EN
        exp_h[0] = 1; exp_h[1] = 0; exp_h[2] = 1;
        exp_d[0] = 0; exp_d[1] = 1; exp_d[2] = 0;
`else
        exp_h[0] = 0; exp_h[1] = 0; exp_h[2] = 0;
        exp_d[0] = 1; exp_d[1] = 1; exp_d[2] = 1;
`endif

        doReset();
        checkOutput("rst_csb_n", sram_csb_n, 1);
        checkOutput("rst_we_n", sram_we_n, 1);
        checkOutput("rst_addr", sram_addr, 0);
        checkOutput("rst_din", sram_din, 0);
        checkOutput("rst_gnts", {h_gnt, d_gnt}, 0);
        checkOutput("rst_rvalids", {h_rvalid, d_rvalid}, 0);
        checkOutput("rst_h_rdata", h_rdata, 0);
        checkOutput("rst_d_rdata", d_rdata, 0);
        checkOutput("rst_busy", busy, 0);

        // Host write then read of address 5
        applyStimulus(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        checkOutput("hw_h_gnt", h_gnt, 1);
        checkOutput("hw_d_gnt", d_gnt, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("hw_acc_csb_n", sram_csb_n, 0);
        checkOutput("hw_acc_we_n", sram_we_n, 0);
        checkOutput("hw_acc_addr", sram_addr, 5);
        checkOutput("hw_acc_din", sram_din, 32'hDEADBEEF);
        checkOutput("hw_acc_busy", busy, 1);
        checkOutput("hw_acc_h_gnt", h_gnt, 0);
        tick();
        checkOutput("hw_idle_csb_n", sram_csb_n, 1);
        checkOutput("hw_idle_busy", busy, 0);
        checkOutput("hw_idle_addr_hold", sram_addr, 5);
        applyStimulus(1, 0, 5, 0, 0, 0, 0, 0, 0);
        checkOutput("hr_h_gnt", h_gnt, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("hr_acc_csb_n", sram_csb_n, 0);
        checkOutput("hr_acc_we_n", sram_we_n, 1);
        checkOutput("hr_acc_addr", sram_addr, 5);
        tick();
        checkOutput("hr_rdw_rvalid", h_rvalid, 0);
        checkOutput("hr_rdw_csb_n", sram_csb_n, 1);
        checkOutput("hr_rdw_busy", busy, 1);
        tick();
        checkOutput("hr_rvalid", h_rvalid, 1);
        checkOutput("hr_rdata", h_rdata, 32'hDEADBEEF);
        checkOutput("hr_d_rvalid", d_rvalid, 0);
        checkOutput("hr_busy", busy, 0);
        tick();
        checkOutput("hr_rvalid_pulse", h_rvalid, 0);
        checkOutput("hr_rdata_hold", h_rdata, 32'hDEADBEEF);

        // DPU write/read of address 9 must leave host read data alone
        applyStimulus(0, 0, 0, 0, 1, 1, 9, 32'h0BADF00D, 0);
        checkOutput("dw_d_gnt", d_gnt, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 0, 9, 0, 0);
        checkOutput("dr_d_gnt", d_gnt, 1);
        checkOutput("dr_h_gnt", h_gnt, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        checkOutput("dr_d_rvalid", d_rvalid, 1);
        checkOutput("dr_d_rdata", d_rdata, 32'h0BADF00D);
        checkOutput("dr_h_rvalid", h_rvalid, 0);
        checkOutput("dr_h_rdata_hold", h_rdata, 32'hDEADBEEF);
        tick();

        // Back-to-back DPU writes, request held throughout
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 1, 5'(i), 32'h100 + 32'(i), 0);
            checkOutput("b2b_d_gnt", d_gnt, 1);
            checkOutput("b2b_idle_csb_n", sram_csb_n, 1);
            tick();
            if (i == 3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput("b2b_acc_csb_n", sram_csb_n, 0);
            checkOutput("b2b_acc_we_n", sram_we_n, 0);
            checkOutput("b2b_acc_addr", sram_addr, 32'(i));
            checkOutput("b2b_rvalid", {h_rvalid, d_rvalid}, 0);
            tick();
        end
        applyStimulus(1, 0, 2, 0, 0, 0, 0, 0, 0);
        checkOutput("b2b_rb_h_gnt", h_gnt, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        checkOutput("b2b_rb_rdata", h_rdata, 32'h102);
        tick();

        // Contention with both requests held, starting from reset
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 5, 0, 1, 0, 9, 0, 0);
            checkOutput("arb_h_gnt", h_gnt, 32'(exp_h[i]));
            checkOutput("arb_d_gnt", d_gnt, 32'(exp_d[i]));
            tick();
            if (i == 2) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput("arb_acc_gnts", {h_gnt, d_gnt}, 0);
            tick();
            checkOutput("arb_rdw_gnts", {h_gnt, d_gnt}, 0);
            tick();
            checkOutput("arb_h_rvalid", h_rvalid, 32'(exp_h[i]));
            checkOutput("arb_d_rvalid", d_rvalid, 32'(exp_d[i]));
        end
        tick();

        // DPU lock across read-modify-write of address 3
        applyStimulus(0, 0, 0, 0, 1, 0, 3, 0, 1);
        checkOutput("lk_rd_d_gnt", d_gnt, 1);
        tick();
        applyStimulus(1, 0, 3, 0, 0, 0, 0, 0, 1);
        checkOutput("lk_acc_h_gnt", h_gnt, 0);
        tick();
        checkOutput("lk_rdw_h_gnt", h_gnt, 0);
        tick();
        applyStimulus(1, 0, 3, 0, 1, 1, 3, 32'h33, 1);
        checkOutput("lk_wr_d_rvalid", d_rvalid, 1);
        checkOutput("lk_wr_d_gnt", d_gnt, 1);
        checkOutput("lk_wr_h_gnt", h_gnt, 0);
        tick();
        applyStimulus(1, 0, 3, 0, 0, 0, 0, 0, 1);
        checkOutput("lk_wacc_h_gnt", h_gnt, 0);
        tick();
        checkOutput("lk_idle_locked_h_gnt", h_gnt, 0);
        checkOutput("lk_idle_busy", busy, 0);
        tick();
        applyStimulus(1, 0, 3, 0, 0, 0, 0, 0, 0);
        checkOutput("lk_release_h_gnt", h_gnt, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        checkOutput("lk_h_rdata", h_rdata, 32'h33);
        tick();

        // Reset during RDWAIT of a host read
        applyStimulus(1, 0, 5, 0, 0, 0, 0, 0, 0);
        checkOutput("rr_h_gnt", h_gnt, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("rr_rdw_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checkOutput("rr_h_rvalid", h_rvalid, 0);
        checkOutput("rr_h_rdata", h_rdata, 0);
        checkOutput("rr_csb_n", sram_csb_n, 1);
        checkOutput("rr_busy", busy, 0);
        checkOutput("rr_addr", sram_addr, 0);
        tick();
        checkOutput("rr_no_late_rvalid", h_rvalid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
